// File: rtl/pla_cube_engine.sv
// Programmable cube-table PLA: a loadable table of (care, value, output-mask) terms,
// scanned TERMS_PER_CYCLE at a time per input vector. Optional macro PLA_OUT_PHASE_EN adds output phase inversion.
`timescale 1ns/1ps
module pla_cube_engine #(
  parameter int N_IN            = 22,
  parameter int N_OUT           = 29,
  parameter int N_TERMS         = 64,
  parameter int TERMS_PER_CYCLE = 4
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic                                          cfg_we,
  output logic                                          cfg_ready,
  input  logic [((N_TERMS > 1) ? $clog2(N_TERMS) : 1)-1:0] cfg_addr,
  input  logic [N_IN-1:0]                               cfg_care,
  input  logic [N_IN-1:0]                               cfg_val,
  input  logic [N_OUT-1:0]                              cfg_out,
  input  logic                                          cfg_en,
`ifdef PLA_OUT_PHASE_EN
  input  logic                                          cfg_inv_we,
  input  logic [N_OUT-1:0]                              cfg_inv,
`endif
  input  logic                                          in_valid,
  output logic                                          in_ready,
  input  logic [N_IN-1:0]                               in_x,
  output logic                                          out_valid,
  input  logic                                          out_ready,
  output logic [N_OUT-1:0]                              out_z
);

  localparam int AW = (N_TERMS > 1) ? $clog2(N_TERMS) : 1;
  localparam logic [AW-1:0] LAST_PTR = AW'(N_TERMS - TERMS_PER_CYCLE);
  localparam logic [AW-1:0] PTR_STEP = AW'(TERMS_PER_CYCLE);

  typedef enum logic [1:0] {S_IDLE, S_EVAL, S_DONE} state_t;

  state_t                state;
  logic [N_IN-1:0]       care_tab [N_TERMS];
  logic [N_IN-1:0]       val_tab  [N_TERMS];
  logic [N_OUT-1:0]      out_tab  [N_TERMS];
  logic [N_TERMS-1:0]    en_tab;
  logic [N_IN-1:0]       x_p0;
  logic [N_OUT-1:0]      acc_p0;
  logic [AW-1:0]         ptr_p0;
  logic [N_OUT-1:0]      acc_nxt;
  logic [AW-1:0]         idx;
  logic [N_OUT-1:0]      inv_mask;
  logic                  addr_ok;
  logic                  wr_ok;

  function automatic logic term_hit(input logic en, input logic [N_IN-1:0] x,
                                    input logic [N_IN-1:0] val, input logic [N_IN-1:0] care);
    return en && (((x ^ val) & care) == '0);
  endfunction

  // Non-power-of-two depths leave addresses past the table reachable; those writes are dropped.
  assign addr_ok = ({1'b0, cfg_addr} < (AW+1)'(N_TERMS));
  assign wr_ok   = cfg_we && cfg_ready && addr_ok;

  always_ff @(posedge clk) begin
    if (wr_ok) begin
      care_tab[cfg_addr] <= cfg_care;
      val_tab[cfg_addr]  <= cfg_val;
      out_tab[cfg_addr]  <= cfg_out;
    end
  end

  // Eval stage: OR the output masks of every matching term in the current group.
  always_comb begin
    acc_nxt = acc_p0;
    idx     = '0;
    for (int k = 0; k < TERMS_PER_CYCLE; k++) begin
      idx = ptr_p0 + AW'(k);
      if (term_hit(en_tab[idx], x_p0, val_tab[idx], care_tab[idx]))
        acc_nxt = acc_nxt | out_tab[idx];
    end
  end

  always_ff @(posedge clk) begin
    case (state)
      S_IDLE: begin
        if (in_valid) begin
          x_p0   <= in_x;
          acc_p0 <= '0;
          ptr_p0 <= '0;
        end
      end
      S_EVAL: begin
        acc_p0 <= acc_nxt;
        ptr_p0 <= ptr_p0 + PTR_STEP;
      end
      default: ;
    endcase
  end

`ifdef PLA_OUT_PHASE_EN
  always_ff @(posedge clk) begin
    if (rst)
      inv_mask <= '0;
    else if (cfg_inv_we && cfg_ready)
      inv_mask <= cfg_inv;
  end
`else
  assign inv_mask = '0;
`endif

  // Control FSM with registered handshake outputs; out_z is held at zero outside DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      en_tab    <= '0;
      out_valid <= 1'b0;
      out_z     <= '0;
      in_ready  <= 1'b1;
      cfg_ready <= 1'b1;
    end else begin
      if (wr_ok)
        en_tab[cfg_addr] <= cfg_en;
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            state     <= S_EVAL;
            in_ready  <= 1'b0;
            cfg_ready <= 1'b0;
          end
        end
        S_EVAL: begin
          if (ptr_p0 == LAST_PTR) begin
            state     <= S_DONE;
            out_valid <= 1'b1;
            out_z     <= acc_nxt ^ inv_mask;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            state     <= S_IDLE;
            out_valid <= 1'b0;
            out_z     <= '0;
            in_ready  <= 1'b1;
            cfg_ready <= 1'b1;
          end
        end
        default: begin
          state     <= S_IDLE;
          out_valid <= 1'b0;
          out_z     <= '0;
          in_ready  <= 1'b1;
          cfg_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pla_cube_engine.sv
// Scoreboard bench for pla_cube_engine: directed vectors push expected out_z, a monitor pops on output handshakes.
`timescale 1ns/1ps
module tb_pla_cube_engine;

  localparam int N_IN    = 22;
  localparam int N_OUT   = 29;
  localparam int N_TERMS = 64;
  localparam int TPC     = 4;
  localparam int LAT     = N_TERMS / TPC + 1;
  localparam int PERIOD  = N_TERMS / TPC + 2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              cfg_we = 1'b0;
  logic              cfg_ready;
  logic [5:0]        cfg_addr = '0;
  logic [N_IN-1:0]   cfg_care = '0;
  logic [N_IN-1:0]   cfg_val = '0;
  logic [N_OUT-1:0]  cfg_out = '0;
  logic              cfg_en = 1'b0;
`ifdef PLA_OUT_PHASE_EN
  logic              cfg_inv_we = 1'b0;
  logic [N_OUT-1:0]  cfg_inv = '0;
`endif
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [N_IN-1:0]   in_x = '0;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [N_OUT-1:0]  out_z;

  always #5 clk = ~clk;

  pla_cube_engine #(.N_IN(N_IN), .N_OUT(N_OUT), .N_TERMS(N_TERMS), .TERMS_PER_CYCLE(TPC)) dut (
    .clk(clk), .rst(rst),
    .cfg_we(cfg_we), .cfg_ready(cfg_ready), .cfg_addr(cfg_addr),
    .cfg_care(cfg_care), .cfg_val(cfg_val), .cfg_out(cfg_out), .cfg_en(cfg_en),
`ifdef PLA_OUT_PHASE_EN
    .cfg_inv_we(cfg_inv_we), .cfg_inv(cfg_inv),
`endif
    .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x),
    .out_valid(out_valid), .out_ready(out_ready), .out_z(out_z)
  );

  int               n_checks = 0;
  int               n_pass = 0;
  logic [N_OUT-1:0] exp_q[$];
  logic [N_OUT-1:0] exp_m;
  time              last_hs = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Monitor: compare each accepted result against the oldest expectation.
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_result: got out_z=%0h with no expected entry", out_z);
        end else begin
          exp_m = exp_q.pop_front();
          check("out_z", 64'(out_z), 64'(exp_m));
        end
      end else if (!out_valid) begin
        check("mask_zero", 64'(out_z), 64'(0));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!in_ready && n < 100) begin
      tick();
      n++;
    end
    check("idle_reached", 64'(in_ready), 64'(1));
  endtask

  task automatic set_term(input int addr, input logic [N_IN-1:0] care, input logic [N_IN-1:0] val,
                          input logic [N_OUT-1:0] outm, input logic en);
    wait_idle();
    cfg_addr = 6'(addr);
    cfg_care = care;
    cfg_val  = val;
    cfg_out  = outm;
    cfg_en   = en;
    cfg_we   = 1'b1;
    tick();
    cfg_we   = 1'b0;
  endtask

  task automatic eval(input logic [N_IN-1:0] x, input logic [N_OUT-1:0] exp, input bit wr);
    int lat;
    wait_idle();
    exp_q.push_back(exp);
    in_x     = x;
    in_valid = 1'b1;
    cfg_we   = wr;
    tick();
    last_hs  = $time;
    in_valid = 1'b0;
    cfg_we   = 1'b0;
    lat = 1;
    while (!out_valid && lat < 100) begin
      tick();
      lat++;
    end
    check("latency", 64'(lat), 64'(LAT));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int  lat;
    int  cnt;
    time t0;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_out_z", 64'(out_z), 64'(0));
    check("rst_in_ready", 64'(in_ready), 64'(1));
    check("rst_cfg_ready", 64'(cfg_ready), 64'(1));

    // Empty table.
    eval(22'h3FFFFF, 29'h0, 1'b0);

    // Populate: bit-0 term, always-on term, two-bit cube, disabled catch-all.
    set_term(0,  22'h000001, 22'h000001, 29'h0000001, 1'b1);
    set_term(63, 22'h000000, 22'h000000, 29'h10000000, 1'b1);
    set_term(33, 22'h300000, 22'h100000, 29'h00000F0, 1'b1);
    set_term(40, 22'h000000, 22'h000000, 29'h1FFFFFFF, 1'b0);
    eval(22'h000001, 29'h10000001, 1'b0);
    t0 = last_hs;
    eval(22'h000000, 29'h10000000, 1'b0);
    check("period", 64'((last_hs - t0) / 10), 64'(PERIOD));
    eval(22'h100001, 29'h100000F1, 1'b0);
    eval(22'h300000, 29'h10000000, 1'b0);

    // Back-pressure in DONE, with writes attempted during EVAL and DONE.
    wait_idle();
    out_ready = 1'b0;
    exp_q.push_back(29'h10000001);
    in_x = 22'h000001;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 100) begin
      if (lat == 3) begin
        cfg_addr = 6'd11; cfg_care = '0; cfg_val = '0; cfg_out = 29'h400; cfg_en = 1'b1; cfg_we = 1'b1;
      end else begin
        cfg_we = 1'b0;
      end
      tick();
      lat++;
    end
    cfg_we = 1'b0;
    check("bp_latency", 64'(lat), 64'(LAT));
    for (int i = 0; i < 5; i++) begin
      check("bp_out_valid", 64'(out_valid), 64'(1));
      check("bp_out_z", 64'(out_z), 64'(29'h10000001));
      check("bp_in_ready", 64'(in_ready), 64'(0));
      check("bp_cfg_ready", 64'(cfg_ready), 64'(0));
      if (i == 2) begin
        cfg_addr = 6'd10; cfg_care = '0; cfg_val = '0; cfg_out = 29'h800; cfg_en = 1'b1; cfg_we = 1'b1;
      end else begin
        cfg_we = 1'b0;
      end
      tick();
    end
    cfg_we = 1'b0;
    out_ready = 1'b1;
    tick();
    check("bp_release_valid", 64'(out_valid), 64'(0));
    check("bp_release_in_ready", 64'(in_ready), 64'(1));
    eval(22'h000000, 29'h10000000, 1'b0);

    // Write and capture in the same cycle; the new term must be visible.
    wait_idle();
    cfg_addr = 6'd5; cfg_care = 22'h000002; cfg_val = 22'h000002; cfg_out = 29'h4; cfg_en = 1'b1;
    eval(22'h000002, 29'h10000004, 1'b1);
    eval(22'h000000, 29'h10000000, 1'b0);

    // Reset during EVAL cycle 8 aborts the vector and clears the table enables.
    wait_idle();
    in_x = 22'h3FFFFF;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (7) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_in_ready", 64'(in_ready), 64'(1));
    check("abort_cfg_ready", 64'(cfg_ready), 64'(1));
    cnt = 0;
    for (int i = 0; i < 25; i++) begin
      if (out_valid) cnt++;
      tick();
    end
    check("abort_no_result", 64'(cnt), 64'(0));
    eval(22'h3FFFFF, 29'h0, 1'b0);
    eval(22'h000000, 29'h0, 1'b0);
    eval(22'h000002, 29'h0, 1'b0);

`ifdef PLA_OUT_PHASE_EN
    wait_idle();
    cfg_inv = 29'h3;
    cfg_inv_we = 1'b1;
    tick();
    cfg_inv_we = 1'b0;
    eval(22'h000000, 29'h3, 1'b0);
    set_term(0, 22'h000001, 22'h000001, 29'h1, 1'b1);
    eval(22'h000001, 29'h2, 1'b0);
`endif

    cnt = 0;
    while (exp_q.size() != 0 && cnt < 100) begin
      tick();
      cnt++;
    end
    check("queue_drained", 64'(exp_q.size()), 64'(0));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
